// File: rtl/spi_master_param.sv
// SPI master engine: runtime CPOL/CPHA, DATA_W-bit words, SCLK half-period of DIV clocks, NUM_SS selects.
// Optional macro SPI_LSB_FIRST_EN adds lsb_first_i to choose LSB-first bit order per transfer.
module spi_master_param #(
  parameter  int DATA_W = 32,
  parameter  int DIV    = 4,
  parameter  int NUM_SS = 2,
  localparam int SSW    = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clck_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic [SSW-1:0]    ss_sel_i,
  input  logic [DATA_W-1:0] tx_data_i,
`ifdef SPI_LSB_FIRST_EN
  input  logic              lsb_first_i,
`endif
  input  logic              miso_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              mosi_o,
  output logic              sclk_o,
  output logic [NUM_SS-1:0] ss_o
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int EW = $clog2(2 * DATA_W);
  localparam logic [TW-1:0] TMR_LAST  = TW'(DIV - 1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(2 * DATA_W - 1);

  typedef enum logic [2:0] {IDLE, LEAD, XFER, TRAIL, DONE} state_t;

  typedef struct packed {
    logic           cpol;
    logic           cpha;
    logic           lsb;
    logic [SSW-1:0] sel;
  } cfg_t;

  state_t            state, state_nxt;
  cfg_t              cfg, cfg_nxt;
  logic [TW-1:0]     tmr;
  logic [EW-1:0]     ecnt, edge_idx;
  logic [DATA_W-1:0] tx_sr, rx_sr;
  logic              lsb_in, accept, tmr_last, edge_fire, lead_edge, shift_ev, sample_ev;
  logic              busy_nxt, done_nxt, sclk_nxt, mosi_nxt;
  logic [NUM_SS-1:0] ss_nxt;

`ifdef SPI_LSB_FIRST_EN
  assign lsb_in = lsb_first_i;
`else
  assign lsb_in = 1'b0;
`endif

  function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_w(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  // Edge k of the transfer: even k is the leading SCLK edge, odd k the trailing one.
  assign accept    = (state == IDLE) && start_i;
  assign tmr_last  = (tmr == TMR_LAST);
  assign edge_fire = tmr_last && ((state == LEAD) || (state == XFER && ecnt != EDGE_LAST));
  assign edge_idx  = (state == LEAD) ? '0 : ecnt + EW'(1);
  assign lead_edge = ~edge_idx[0];
  assign shift_ev  = edge_fire && (cfg.cpha ? lead_edge : (!lead_edge && edge_idx != EDGE_LAST));
  assign sample_ev = edge_fire && (cfg.cpha ? !lead_edge : lead_edge);

  always_comb begin
    cfg_nxt = cfg;
    if (accept) begin
      cfg_nxt.cpol = cpol_i;
      cfg_nxt.cpha = cpha_i;
      cfg_nxt.lsb  = lsb_in;
      cfg_nxt.sel  = ss_sel_i;
    end
  end

  always_ff @(posedge clck_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i)                      state_nxt = LEAD;
      LEAD:    if (tmr_last)                     state_nxt = XFER;
      XFER:    if (tmr_last && ecnt == EDGE_LAST) state_nxt = TRAIL;
      TRAIL:   if (tmr_last)                     state_nxt = DONE;
      DONE:                                      state_nxt = IDLE;
      default:                                   state_nxt = IDLE;
    endcase
  end

  // Outputs are computed from the next state and registered, so pins never see a comb path.
  always_comb begin
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == DONE);
    sclk_nxt = cfg_nxt.cpol;
    if (state_nxt == XFER) sclk_nxt = edge_fire ? ~sclk_o : sclk_o;
    mosi_nxt = mosi_o;
    if (state_nxt == IDLE || state_nxt == DONE) mosi_nxt = 1'b0;
    else if (accept)                            mosi_nxt = cpha_i ? 1'b0 : first_bit(tx_data_i, lsb_in);
    else if (shift_ev)                          mosi_nxt = first_bit(tx_sr, cfg.lsb);
    for (int i = 0; i < NUM_SS; i++)
      ss_nxt[i] = !(busy_nxt && !done_nxt && cfg_nxt.sel == SSW'(i));
  end

  always_ff @(posedge clck_i or negedge rst_i) begin
    if (!rst_i) begin
      busy_o <= 1'b0;
      done_o <= 1'b0;
      mosi_o <= 1'b0;
      sclk_o <= 1'b0;
      ss_o   <= '1;
    end else begin
      busy_o <= busy_nxt;
      done_o <= done_nxt;
      mosi_o <= mosi_nxt;
      sclk_o <= sclk_nxt;
      ss_o   <= ss_nxt;
    end
  end

  // For CPHA=0 the first bit is already on mosi at LEAD, so tx_sr starts one bit ahead.
  always_ff @(posedge clck_i or negedge rst_i) begin
    if (!rst_i) begin
      cfg       <= '0;
      tmr       <= '0;
      ecnt      <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      rx_data_o <= '0;
    end else begin
      cfg <= cfg_nxt;
      tmr <= (state == IDLE || tmr_last) ? '0 : tmr + TW'(1);
      if (edge_fire) ecnt <= edge_idx;
      if (accept)        tx_sr <= cpha_i ? tx_data_i : shift_w(tx_data_i, lsb_in);
      else if (shift_ev) tx_sr <= shift_w(tx_sr, cfg.lsb);
      if (accept)         rx_sr <= '0;
      else if (sample_ev) rx_sr <= cfg.lsb ? {miso_i, rx_sr[DATA_W-1:1]}
                                           : {rx_sr[DATA_W-2:0], miso_i};
      if (state_nxt == DONE) rx_data_o <= rx_sr;
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Self-checking bench for spi_master_param: loopback and modelled-slave transfers, scoreboard of expected words.
module tb_spi_master_param;
  localparam int DATA_W   = 8;
  localparam int DIV      = 2;
  localparam int NUM_SS   = 3;
  localparam int DONE_CYC = 1 + DIV * (2 * DATA_W + 2);

  logic       clk = 0, rst_n = 1, start = 0, cpol = 0, cpha = 0, lsb_first = 0, loopback = 1;
  logic [1:0] ss_sel = 0;
  logic [7:0] tx_data = 0;
  logic       miso, busy, done, mosi, sclk;
  logic [7:0] rx_data;
  logic [2:0] ss;

  logic [7:0] slv_word = 0, slv_rx = 0;
  logic       slv_miso;
  int         nfall = 0;

  int         tests_run = 0, tests_failed = 0;
  logic [7:0] exp_q[$];
  int         sclk_rise = 0, mosi_bad = 0, done_seen = 0, ss_act = 0;
  logic       p_sclk = 0, p_mosi = 0;
  logic [2:0] p_ss = '1;

  spi_master_param #(.DATA_W(DATA_W), .DIV(DIV), .NUM_SS(NUM_SS)) dut (
    .clck_i(clk), .rst_i(rst_n), .start_i(start), .cpol_i(cpol), .cpha_i(cpha),
    .ss_sel_i(ss_sel), .tx_data_i(tx_data),
`ifdef SPI_LSB_FIRST_EN
    .lsb_first_i(lsb_first),
`endif
    .miso_i(miso), .busy_o(busy), .done_o(done), .rx_data_o(rx_data),
    .mosi_o(mosi), .sclk_o(sclk), .ss_o(ss)
  );

  always #5 clk = ~clk;
  assign miso = loopback ? mosi : slv_miso;

  // Mode-3 slave on select 0: drives on falling SCLK, captures on rising SCLK, MSB first.
  always @(negedge sclk or posedge ss[0]) begin
    if (ss[0]) nfall <= 0;
    else       nfall <= nfall + 1;
  end
  always_comb begin
    slv_miso = 1'b0;
    if (nfall >= 1 && nfall <= 8) slv_miso = slv_word[3'(8 - nfall)];
  end
  always @(posedge sclk) if (!ss[0]) slv_rx <= {slv_rx[6:0], mosi};

  always @(negedge clk) begin
    if (rst_n) begin
      if (!ss[0] && !p_sclk && sclk) sclk_rise <= sclk_rise + 1;
      if (!ss[0] && !p_ss[0] && mosi != p_mosi && !(p_sclk && !sclk)) mosi_bad <= mosi_bad + 1;
      if (done) done_seen <= done_seen + 1;
      if (ss != 3'b111) ss_act <= ss_act + 1;
    end
    p_sclk <= sclk;
    p_mosi <= mosi;
    p_ss   <= ss;
  end

  task automatic kick(input logic [7:0] tx, input logic pol, input logic pha,
                      input logic [1:0] sel, input logic lsb, input logic [7:0] exp);
    @(negedge clk);
    tx_data = tx; cpol = pol; cpha = pha; ss_sel = sel; start = 1;
    lsb_first = lsb;
    exp_q.push_back(exp);
    @(posedge clk);
    #1 start = 0;
  endtask

  task automatic wait_done(output int n, output logic ok);
    n = 0; ok = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      n++;
      if (done) ok = 1;
    end
  endtask

  task automatic test_reset;
    #2 rst_n = 0;
    repeat (3) @(negedge clk);
    tests_run++; if (busy !== 1'b0)     begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++; if (done !== 1'b0)     begin tests_failed++; $display("FAIL reset_done: got %b want 0", done); end
    tests_run++; if (rx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_rx: got %h want 00", rx_data); end
    tests_run++; if (mosi !== 1'b0)     begin tests_failed++; $display("FAIL reset_mosi: got %b want 0", mosi); end
    tests_run++; if (sclk !== 1'b0)     begin tests_failed++; $display("FAIL reset_sclk: got %b want 0", sclk); end
    tests_run++; if (ss !== 3'b111)     begin tests_failed++; $display("FAIL reset_ss: got %b want 111", ss); end
    rst_n = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mode0_loopback;
    int n; logic ok; int r0, d0; logic [7:0] e;
    r0 = sclk_rise; d0 = done_seen;
    kick(8'hA5, 0, 0, 2'd0, 0, 8'hA5);
    wait_done(n, ok);
    tests_run++; if (!ok || n != DONE_CYC) begin tests_failed++; $display("FAIL m0_done_cycle: got %0d want %0d", n, DONE_CYC); end
    e = exp_q.size() ? exp_q.pop_front() : 8'hxx;
    tests_run++; if (rx_data !== e) begin tests_failed++; $display("FAIL m0_rx: got %h want %h", rx_data, e); end
    @(negedge clk); #1;
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL m0_done_width: got %b want 0", done); end
    tests_run++; if (sclk_rise - r0 != 8) begin tests_failed++; $display("FAIL m0_sclk_rises: got %0d want 8", sclk_rise - r0); end
    tests_run++; if (done_seen - d0 != 1) begin tests_failed++; $display("FAIL m0_done_count: got %0d want 1", done_seen - d0); end
  endtask

  task automatic test_modes_loopback;
    int n; logic ok; logic [7:0] t, e; logic [1:0] mm;
    for (int m = 1; m < 4; m++) begin
      mm = 2'(m);
      t = 8'($urandom_range(255, 0));
      kick(t, mm[1], mm[0], 2'd0, 0, t);
      wait_done(n, ok);
      e = exp_q.size() ? exp_q.pop_front() : 8'hxx;
      tests_run++; if (!ok || rx_data !== e) begin tests_failed++; $display("FAIL mode%0d_rx: got %h want %h", m, rx_data, e); end
    end
  endtask

  task automatic test_mode3_slave;
    int n; logic ok; int b0; logic [7:0] e;
    loopback = 0; slv_word = 8'hC3;
    repeat (2) @(negedge clk);
    b0 = mosi_bad;
    kick(8'h3C, 1, 1, 2'd0, 0, 8'hC3);
    wait_done(n, ok);
    tests_run++; if (!ok || n != DONE_CYC) begin tests_failed++; $display("FAIL m3_done_cycle: got %0d want %0d", n, DONE_CYC); end
    e = exp_q.size() ? exp_q.pop_front() : 8'hxx;
    tests_run++; if (rx_data !== e) begin tests_failed++; $display("FAIL m3_rx: got %h want %h", rx_data, e); end
    repeat (2) @(negedge clk); #1;
    tests_run++; if (slv_rx !== 8'h3C) begin tests_failed++; $display("FAIL m3_slave_rx: got %h want 3c", slv_rx); end
    tests_run++; if (sclk !== 1'b1) begin tests_failed++; $display("FAIL m3_sclk_idle: got %b want 1", sclk); end
    tests_run++; if (mosi_bad != b0) begin tests_failed++; $display("FAIL m3_mosi_edge: got %0d off-edge changes want 0", mosi_bad - b0); end
    loopback = 1;
  endtask

  task automatic test_start_while_busy;
    int n; logic ok; int d0; logic [7:0] e;
    d0 = done_seen;
    kick(8'h96, 0, 0, 2'd0, 0, 8'h96);
    repeat (9) @(negedge clk);
    tx_data = 8'hFF; start = 1;
    @(posedge clk); #1 start = 0;
    wait_done(n, ok);
    e = exp_q.size() ? exp_q.pop_front() : 8'hxx;
    tests_run++; if (!ok || rx_data !== e) begin tests_failed++; $display("FAIL busy_rx: got %h want %h", rx_data, e); end
    repeat (50) @(negedge clk); #1;
    tests_run++; if (done_seen - d0 != 1) begin tests_failed++; $display("FAIL busy_done_count: got %0d want 1", done_seen - d0); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL busy_idle: got %b want 0", busy); end
  endtask

  task automatic test_slave_select;
    int n; logic ok; int a0; logic [7:0] e;
    kick(8'h11, 0, 0, 2'd1, 0, 8'h11);
    repeat (10) @(negedge clk);
    tests_run++; if (ss !== 3'b101) begin tests_failed++; $display("FAIL ss1_lines: got %b want 101", ss); end
    wait_done(n, ok);
    e = exp_q.size() ? exp_q.pop_front() : 8'hxx;
    tests_run++; if (!ok || rx_data !== e) begin tests_failed++; $display("FAIL ss1_rx: got %h want %h", rx_data, e); end
    @(negedge clk); #1;
    a0 = ss_act;
    kick(8'h6B, 0, 0, 2'd3, 0, 8'h6B);
    wait_done(n, ok);
    tests_run++; if (!ok || n != DONE_CYC) begin tests_failed++; $display("FAIL ss_oor_done: got %0d want %0d", n, DONE_CYC); end
    e = exp_q.size() ? exp_q.pop_front() : 8'hxx;
    tests_run++; if (rx_data !== e) begin tests_failed++; $display("FAIL ss_oor_rx: got %h want %h", rx_data, e); end
    @(negedge clk); #1;
    tests_run++; if (ss_act != a0) begin tests_failed++; $display("FAIL ss_oor_lines: got %0d active cycles want 0", ss_act - a0); end
  endtask

  task automatic test_reset_mid;
    int n; logic ok; int d0; logic [7:0] e;
    d0 = done_seen;
    kick(8'hE7, 0, 0, 2'd0, 0, 8'hE7);
    repeat (14) @(negedge clk);
    rst_n = 0;
    #1;
    tests_run++; if (ss !== 3'b111) begin tests_failed++; $display("FAIL rmid_ss: got %b want 111", ss); end
    tests_run++; if (sclk !== 1'b0) begin tests_failed++; $display("FAIL rmid_sclk: got %b want 0", sclk); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rmid_busy: got %b want 0", busy); end
    tests_run++; if (mosi !== 1'b0) begin tests_failed++; $display("FAIL rmid_mosi: got %b want 0", mosi); end
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (45) @(negedge clk); #1;
    tests_run++; if (done_seen != d0) begin tests_failed++; $display("FAIL rmid_no_done: got %0d pulses want 0", done_seen - d0); end
    kick(8'h5A, 0, 0, 2'd0, 0, 8'h5A);
    wait_done(n, ok);
    e = exp_q.size() ? exp_q.pop_front() : 8'hxx;
    tests_run++; if (!ok || n != DONE_CYC || rx_data !== e) begin tests_failed++; $display("FAIL rmid_next: got %h at %0d want %h at %0d", rx_data, n, e, DONE_CYC); end
  endtask

  task automatic test_back_to_back;
    int n; logic ok; logic [7:0] e;
    @(negedge clk);
    tx_data = 8'h3A; cpol = 0; cpha = 0; ss_sel = 0; start = 1;
    exp_q.push_back(8'h3A);
    exp_q.push_back(8'hC5);
    @(posedge clk);
    #1 tx_data = 8'hC5;
    wait_done(n, ok);
    tests_run++; if (!ok || n != DONE_CYC) begin tests_failed++; $display("FAIL b2b_first_done: got %0d want %0d", n, DONE_CYC); end
    e = exp_q.size() ? exp_q.pop_front() : 8'hxx;
    tests_run++; if (rx_data !== e) begin tests_failed++; $display("FAIL b2b_first_rx: got %h want %h", rx_data, e); end
    @(posedge clk);
    @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_gap_busy: got %b want 0", busy); end
    @(posedge clk);
    #1 start = 0;
    wait_done(n, ok);
    tests_run++; if (!ok || n != DONE_CYC) begin tests_failed++; $display("FAIL b2b_second_done: got %0d want %0d", n, DONE_CYC); end
    e = exp_q.size() ? exp_q.pop_front() : 8'hxx;
    tests_run++; if (rx_data !== e) begin tests_failed++; $display("FAIL b2b_second_rx: got %h want %h", rx_data, e); end
  endtask

`ifdef SPI_LSB_FIRST_EN
  task automatic test_lsb_first;
    int n; logic ok; logic [7:0] e;
    kick(8'h01, 0, 0, 2'd0, 1, 8'h01);
    tests_run++; if (mosi !== 1'b1) begin tests_failed++; $display("FAIL lsb_first_bit: got %b want 1", mosi); end
    wait_done(n, ok);
    e = exp_q.size() ? exp_q.pop_front() : 8'hxx;
    tests_run++; if (!ok || rx_data !== e) begin tests_failed++; $display("FAIL lsb_rx: got %h want %h", rx_data, e); end
  endtask
`endif

  initial begin
    test_reset();
    test_mode0_loopback();
    test_modes_loopback();
    test_mode3_slave();
    test_start_while_busy();
    test_slave_select();
    test_reset_mid();
    test_back_to_back();
`ifdef SPI_LSB_FIRST_EN
    test_lsb_first();
`endif
    repeat (3) @(negedge clk);
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL scoreboard_left: got %0d entries want 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
